serial_compare_ctrl: RTL and testbench
======================================

// Module: serial_compare_ctrl
// PURPOSE
//  Sequencer for a 1-bit magnitude comparator cell (outputs gt/eq/lt). Compares two WIDTH-bit
//  operands bit-serially, MSB first, with a start/done handshake. Sits between the register
//  datapath and the comparator cell, so one comparator slice serves multi-bit compares.
// PARAMETERS
//  WIDTH      8   operand width in bits; legal range 2..32
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      request a compare; sampled only in IDLE
//  a_in       in   WIDTH  operand A; captured on the accepted start
//  b_in       in   WIDTH  operand B; captured on the accepted start
//  busy       out  1      high in SHIFT and DONE
//  done       out  1      one-cycle pulse when the result is valid
//  gt         out  1      A > B, held until the next accepted start
//  eq         out  1      A == B, held
//  lt         out  1      A < B, held
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset: all outputs are 0 and the FSM is in IDLE. gt/eq/lt = 000 means no result yet.
//  - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//    - IDLE: start=1 latches a_in/b_in into a_r/b_r, sets idx=WIDTH-1, clears the decision flag,
//      clears gt/eq/lt, and moves to SHIFT.
//    - SHIFT: each cycle the cell compares a_r[idx] and b_r[idx].
//      - If the decision flag is clear and the bits differ: latch gt_r=a_r[idx], lt_r=~a_r[idx]
//        and set the flag.
//      - A set flag is sticky; lower bits are then ignored.
//      - idx decrements each cycle. When idx==0 is processed, the FSM moves to DONE.
//    - DONE: done=1 for exactly one cycle. gt/eq/lt are driven from gt_r/lt_r;
//      eq = ~flag. The FSM then returns to IDLE.
//  - Latency: an accepted start at edge 0 gives done high after edge WIDTH+1 (WIDTH SHIFT
//    cycles plus 1 DONE cycle).
//  - gt/eq/lt are one-hot once any compare has completed. They are stable from done until the
//    next accepted start.
//  - start in SHIFT or DONE is ignored and not queued. Changes to a_in/b_in after capture have
//    no effect.
//  - start held high continuously gives back-to-back compares, with one IDLE cycle between them.
//  - rst_n low mid-operation: outputs go to 0 immediately, the FSM goes to IDLE, and the
//    partial result is discarded.
//  - idx is a $clog2(WIDTH)-bit down-counter and never wraps. The SHIFT exit is decoded at
//    idx==0.
// CONFIGURATION
//  EARLY_EXIT_EN defined:
//   - In SHIFT, the first differing bit sends the FSM to DONE on the next edge.
//   - Latency is k+2 edges, where k is the number of equal MSBs above the differing bit.
//     Equal operands still take WIDTH+1.
//  EARLY_EXIT_EN undefined:
//   - Fixed WIDTH+1 latency for all operands.
//   - Result values are identical in both builds.
// TESTING (WIDTH=8; edge 0 = start accepted)
//  1 Reset: rst_n=0, then release -> busy=done=gt=eq=lt=0. Idle with start=0 -> all stay 0.
//  2 a=8'hA5, b=8'hA5 -> done at edge 9 in both builds; eq=1, gt=lt=0; held until next start.
//  3 a=8'h80, b=8'h7F -> gt=1.
//    - EARLY_EXIT_EN: done at edge 2.
//    - Otherwise: done at edge 9.
//  4 a=8'h12, b=8'h13 -> lt=1 (only bit 0 differs); done at edge 9 in both builds.
//  5 Start 8'h01 vs 8'h02, then:
//    - pulse start with a_in=8'hFF at edge 3 -> ignored;
//    - result lt=1, exactly one done pulse;
//    - a new start after done is accepted.
//  6 rst_n=0 at edge 4 of a compare -> all outputs 0 asynchronously, FSM in IDLE;
//    then 8'h05 vs 8'h03 -> gt=1 with nominal latency.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// serial_compare_ctrl
//
// Purpose:
//   Sequencer for a single 1-bit magnitude comparator cell. Two WIDTH-bit
//   operands are captured on an accepted start and walked MSB first, one bit
//   per clock, through the cell. The first differing bit decides the result;
//   lower bits are ignored after that. The result is published together with a
//   one-cycle done pulse and held until the next accepted start.
//
// Parameters:
//   WIDTH    operand width in bits (2..32)
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      compare request, sampled only while idle
//   a_in     in   WIDTH  operand A, captured on the accepted start
//   b_in     in   WIDTH  operand B, captured on the accepted start
//   busy     out  1      high while shifting and during the done state
//   done     out  1      one-cycle pulse when gt/eq/lt become valid
//   gt       out  1      A > B, held until the next accepted start
//   eq       out  1      A == B, held until the next accepted start
//   lt       out  1      A < B, held until the next accepted start
//
// Build option:
//   EARLY_EXIT_EN  when defined, the first differing bit ends the shift phase
//                  on the next edge (latency k+2, k = number of equal MSBs).
//                  When undefined, every compare takes WIDTH+1 edges.
//                  Result values are the same in both builds.
// -----------------------------------------------------------------------------
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;      // down-counter, stops at 0 (never wraps)
  logic             flag;     // decision taken; sticky until next start
  logic             gt_r;
  logic             lt_r;

  // 1-bit comparator cell: examines the current bit pair.
  logic a_bit;
  logic b_bit;
  logic bit_diff;

  assign a_bit    = a_r[idx];
  assign b_bit    = b_r[idx];
  assign bit_diff = a_bit ^ b_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      flag  <= 1'b0;
      gt_r  <= 1'b0;
      lt_r  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a_in;
            b_r   <= b_in;
            idx   <= IDX_TOP;
            flag  <= 1'b0;
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // Only the first differing bit (from the MSB) decides the result.
          if (!flag && bit_diff) begin
            gt_r <= a_bit;
            lt_r <= ~a_bit;
            flag <= 1'b1;
          end
          if (idx == '0) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
`ifdef EARLY_EXIT_EN
          // A decision is final, so the remaining bits need not be walked.
          if (!flag && bit_diff) begin
            state <= DONE;
          end
`endif
        end

        DONE: begin
          gt    <= gt_r;
          lt    <= lt_r;
          eq    <= ~flag;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
module tb_serial_compare_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  int checks = 0;
  int errors = 0;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .gt    (gt),
    .eq    (eq),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One compare: start accepted at edge 0, watch edges 1..lat+3.
  // pulse_edge > 0 drives a stray start with a_in=FF just before that edge.
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input logic [2:0] res, input int pulse_edge);
    int seen;
    int pulses;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~a;            // must not affect the captured operands
    b_in  = ~b;
    check({tag, "_clr"}, {29'd0, gt, eq, lt}, 32'd0);
    seen   = -1;
    pulses = 0;
    for (int e = 1; e <= lat + 3; e++) begin
      if (e == pulse_edge) begin
        start = 1'b1;
        a_in  = 8'hFF;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (e == 1) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (done) begin
        pulses++;
        if (seen < 0) seen = e;
      end
    end
    check({tag, "_lat"}, seen, lat);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_res"}, {29'd0, gt, eq, lt}, {29'd0, res});
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    $display("cmp %s a=%02h b=%02h lat=%0d gt/eq/lt=%b%b%b", tag, a, b, seen, gt, eq, lt);
  endtask

  int lat_gt80;
  int lat_0102;
  int lat_0503;
  int lat_ff00;

  initial begin
`ifdef EARLY_EXIT_EN
    lat_gt80 = 2;
    lat_0102 = 8;
    lat_0503 = 7;
    lat_ff00 = 2;
`else
    lat_gt80 = 9;
    lat_0102 = 9;
    lat_0503 = 9;
    lat_ff00 = 9;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // 1: reset and idle
    #22;
    check("rst_out", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_out", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    $display("reset/idle busy=%b done=%b gt/eq/lt=%b%b%b", busy, done, gt, eq, lt);

    // 2..4: basic compares
    run_cmp("eq_a5", 8'hA5, 8'hA5, 9, 3'b010, 0);
    run_cmp("gt_80", 8'h80, 8'h7F, lat_gt80, 3'b100, 0);
    run_cmp("lt_12", 8'h12, 8'h13, 9, 3'b001, 0);

    // 5: stray start mid-compare ignored, then next start accepted
    run_cmp("lt_0102", 8'h01, 8'h02, lat_0102, 3'b001, 3);
    run_cmp("gt_ff00", 8'hFF, 8'h00, lat_ff00, 3'b100, 0);

    // 6: reset at edge 4 of a compare
    @(negedge clk);
    a_in  = 8'h55;
    b_in  = 8'h54;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    $display("async reset busy=%b done=%b gt/eq/lt=%b%b%b", busy, done, gt, eq, lt);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst", {27'd0, busy, done, gt, eq, lt}, 32'd0);
    run_cmp("gt_0503", 8'h05, 8'h03, lat_0503, 3'b100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
